// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder for the MEM stage. Holds a word-organised RAM and
//   serves LB/LH/LW/LBU/LHU loads and SB/SH/SW stores with a fixed latency of
//   LATENCY cycles. Busy stalls the pipeline while an access is in flight.
//
//   Parameters
//     ADDR_W   byte-address width; word index = Addr[ADDR_W-1:2]
//     DEPTH    RAM depth in 32-bit words (power of 2); index wraps modulo DEPTH
//     LATENCY  cycles from request accept to response, 1..15
//
//   Ports
//     clk, reset            clock, synchronous active-high reset
//     MemRead, MemWrite     request strobes (both high = store)
//     Funct3                000 B, 001 H, 010 W, 100 BU, 101 HU (others = W)
//     Addr, WrData          byte address and store data
//     RdData, RdValid       load result and its one-cycle valid pulse
//     Busy                  stall request, combinational in IDLE
//     MisalignErr           one-cycle misaligned-access pulse at response
//
//   Build option
//     DMEM_MISALIGN_TRAP_EN  when defined, misaligned H/W accesses are
//                            trapped (no store, load returns 0, MisalignErr
//                            pulses). When undefined, the offending low
//                            address bits are cleared and the access proceeds.
// ---------------------------------------------------------------------------
module dmem_responder #(
   parameter int ADDR_W  = 9,
   parameter int DEPTH   = 128,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [2:0]        Funct3,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [31:0]       WrData,
   output logic [31:0]       RdData,
   output logic              RdValid,
   output logic              Busy,
   output logic              MisalignErr
);

   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

   function automatic size_t size_of(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: return SZ_B;
         3'b001, 3'b101: return SZ_H;
         default:        return SZ_W;   // 010 plus reserved encodings
      endcase
   endfunction

   function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
      return IDX_W'(a >> 2);
   endfunction

   // Select, then sign/zero extend, the addressed lane of a word.
   function automatic logic [31:0] extract(input logic [31:0] w,
                                           input logic [2:0]  f3,
                                           input logic [1:0]  lo);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(w >> {lo, 3'b000});
      h = lo[1] ? w[31:16] : w[15:0];
      case (size_of(f3))
         SZ_B:    return f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
         SZ_H:    return f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
         default: return w;
      endcase
   endfunction

   logic [31:0] mem [DEPTH];

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [2:0]        funct3_q, funct3_d;
   logic              store_q, store_d;
   logic              load_q, load_d;
   logic              mis_q, mis_d;
   logic [31:0]       rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              mis_err_q, mis_err_d;

   logic              req;
   logic [ADDR_W-1:0] req_addr;
   logic              req_mis;
   logic              idle;
   logic [ADDR_W-1:0] acc_addr;
   logic [2:0]        acc_f3;
   logic              acc_load, acc_mis;
   logic [31:0]       wr_old, wr_lane, wr_merge;
   logic [3:0]        wr_be;
   logic              mem_we;

   assign req  = MemRead | MemWrite;
   assign idle = (state_q == S_IDLE);

   // Request address after misalignment handling.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      req_addr = Addr;
      req_mis  = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      req_mis = (size_of(Funct3) == SZ_H && Addr[0]) ||
                (size_of(Funct3) == SZ_W && Addr[1:0] != 2'b00);
`else
      if (size_of(Funct3) == SZ_H)      req_addr[0]   = 1'b0;
      else if (size_of(Funct3) == SZ_W) req_addr[1:0] = 2'b00;
`endif
   end

   // The response is captured on entry to RESP. With LATENCY=1 that entry
   // happens straight from IDLE, so the live request is used instead of the
   // latched copy.
   always_comb begin
      acc_addr = idle ? req_addr : addr_q;
      acc_f3   = idle ? Funct3 : funct3_q;
      acc_load = idle ? (MemRead & ~MemWrite) : load_q;
      acc_mis  = idle ? req_mis : mis_q;
   end

   // Next-state logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      funct3_d = funct3_q;
      store_d  = store_q;
      load_d   = load_q;
      mis_d    = mis_q;
      case (state_q)
         S_IDLE: if (req) begin
            addr_d   = req_addr;
            wdata_d  = WrData;
            funct3_d = Funct3;
            store_d  = MemWrite;
            load_d   = MemRead & ~MemWrite;
            mis_d    = req_mis;
            cnt_d    = 4'(LATENCY - 1);
            state_d  = (LATENCY == 1) ? S_RESP : S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q <= 4'd1) state_d = S_RESP;
            cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      rd_valid_d = (state_d == S_RESP) && acc_load;
      mis_err_d  = (state_d == S_RESP) && acc_mis;
      rd_data_d  = rd_data_q;
      if (rd_valid_d)
         rd_data_d = acc_mis ? 32'h0 : extract(mem[idx_of(acc_addr)], acc_f3, acc_addr[1:0]);
   end

   // Outputs and store strobe.
   always_comb begin
      Busy        = !reset && ((idle && req) || state_q == S_WAIT);
      mem_we      = !reset && (state_q == S_RESP) && store_q && !mis_q;
      RdData      = rd_data_q;
      RdValid     = rd_valid_q;
      // Without the trap build req_mis is constant 0, so this stays low.
      MisalignErr = mis_err_q;
   end

   // Byte-enabled read-modify-write of the single addressed word.
   always_comb begin
      wr_old = mem[idx_of(addr_q)];
      case (size_of(funct3_q))
         SZ_B: begin
            wr_lane = {4{wdata_q[7:0]}};
            wr_be   = 4'b0001 << addr_q[1:0];
         end
         SZ_H: begin
            wr_lane = {2{wdata_q[15:0]}};
            wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            wr_lane = wdata_q;
            wr_be   = 4'b1111;
         end
      endcase
      for (int i = 0; i < 4; i++)
         wr_merge[8*i +: 8] = wr_be[i] ? wr_lane[8*i +: 8] : wr_old[8*i +: 8];
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         funct3_q   <= '0;
         store_q    <= 1'b0;
         load_q     <= 1'b0;
         mis_q      <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         mis_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         funct3_q   <= funct3_d;
         store_q    <= store_d;
         load_q     <= load_d;
         mis_q      <= mis_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         mis_err_q  <= mis_err_d;
      end
   end

   // NOTE: the RAM array has no reset; contents survive reset and map to plain RAM.
   always_ff @(posedge clk) begin
      if (mem_we) mem[idx_of(addr_q)] <= wr_merge;
   end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//   Directed bench for dmem_responder (default parameters: LATENCY=2).
//   Each transaction is observed over a five-cycle window; bit c of the
//   busy/valid/misalign masks is the value sampled in cycle c, where cycle 0
//   is the cycle the request is presented.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead, MemWrite;
   logic [2:0]  Funct3;
   logic [8:0]  Addr;
   logic [31:0] WrData;
   logic [31:0] RdData;
   logic        RdValid, Busy, MisalignErr;

   int checks = 0;
   int errors = 0;

   localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                          F_BU = 3'b100, F_HU = 3'b101, F_RSV = 3'b011;

   dmem_responder dut (
      .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
      .Funct3(Funct3), .Addr(Addr), .WrData(WrData), .RdData(RdData),
      .RdValid(RdValid), .Busy(Busy), .MisalignErr(MisalignErr)
   );

   always #5 clk = ~clk;

   // Present one request and record outputs for five cycles. Strobes are
   // dropped after the posedge ending cycle 'hold'.
   task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [8:0] a, input logic [31:0] wd, input int hold,
                             output logic [4:0] busy_m, output logic [4:0] valid_m,
                             output logic [4:0] mis_m, output logic [31:0] data,
                             output logic [31:0] data_late);
      @(posedge clk); #1;
      MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; WrData = wd;
      busy_m = '0; valid_m = '0; mis_m = '0; data = '0; data_late = '0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         busy_m[c]  = Busy;
         valid_m[c] = RdValid;
         mis_m[c]   = MisalignErr;
         if (RdValid) data = RdData;
         data_late = RdData;
         @(posedge clk); #1;
         if (c >= hold) begin MemRead = 1'b0; MemWrite = 1'b0; end
      end
   endtask

   task automatic do_store(input string name, input logic [2:0] f3, input logic [8:0] a,
                           input logic [31:0] wd, input logic both);
      logic [4:0] b, v, m;
      logic [31:0] d, dl;
      run_access(both, 1'b1, f3, a, wd, 0, b, v, m, d, dl);
      checks++;
      if (b !== 5'b00011 || v !== 5'b00000) begin
         errors++;
         $display("FAIL %s: busy=%b valid=%b, want busy=00011 valid=00000", name, b, v);
      end
   endtask

   task automatic do_load(input string name, input logic [2:0] f3, input logic [8:0] a,
                          input logic [31:0] exp, input int hold);
      logic [4:0] b, v, m;
      logic [31:0] d, dl;
      run_access(1'b1, 1'b0, f3, a, 32'h0, hold, b, v, m, d, dl);
      checks++;
      if (b !== 5'b00011 || v !== 5'b00100) begin
         errors++;
         $display("FAIL %s_timing: busy=%b valid=%b, want busy=00011 valid=00100", name, b, v);
      end
      checks++;
      if (d !== exp) begin
         errors++;
         $display("FAIL %s_data: got %h want %h", name, d, exp);
      end
      checks++;
      if (dl !== exp) begin
         errors++;
         $display("FAIL %s_hold: got %h want %h", name, dl, exp);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; MemRead = 1'b1; MemWrite = 1'b0;
      Funct3 = F_W; Addr = '0; WrData = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (Busy !== 1'b0 || RdValid !== 1'b0 || MisalignErr !== 1'b0 || RdData !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: busy=%b valid=%b mis=%b data=%h, want all 0",
                  Busy, RdValid, MisalignErr, RdData);
      end
      @(posedge clk); #1;
      MemRead = 1'b0; reset = 1'b0;
      @(negedge clk);
      checks++;
      if (Busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_busy: got %b want 0", Busy);
      end
   endtask

   task automatic test_word;
      do_store("sw_010", F_W, 9'h010, 32'hDEADBEEF, 1'b0);
      do_load("lw_010", F_W, 9'h010, 32'hDEADBEEF, 0);
   endtask

   task automatic test_byte;
      do_store("sb_011", F_B, 9'h011, 32'h00000080, 1'b0);
      do_load("lb_011", F_B, 9'h011, 32'hFFFFFF80, 0);
      do_load("lbu_011", F_BU, 9'h011, 32'h00000080, 0);
      do_load("lw_after_sb", F_W, 9'h010, 32'hDEAD80EF, 0);
      do_load("lb_010", F_B, 9'h010, 32'hFFFFFFEF, 0);
   endtask

   task automatic test_half;
      do_store("sh_012", F_H, 9'h012, 32'h00001234, 1'b0);
      do_load("lh_012", F_H, 9'h012, 32'h00001234, 0);
      do_load("lw_after_sh", F_W, 9'h010, 32'h123480EF, 0);
   endtask

   // Strobes held through RESP: only one response may come back.
   task automatic test_held_request;
      do_load("lw_held", F_W, 9'h010, 32'h123480EF, 2);
   endtask

   task automatic test_reset_mid_access;
      do_store("sw_020", F_W, 9'h020, 32'h55551234, 1'b0);
      @(posedge clk); #1;
      MemRead = 1'b0; MemWrite = 1'b1; Funct3 = F_W; Addr = 9'h020; WrData = 32'hAAAAAAAA;
      @(posedge clk); #1;
      MemWrite = 1'b0; reset = 1'b1;
      @(negedge clk);
      checks++;
      if (Busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_busy: got %b want 0", Busy);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (Busy !== 1'b0 || RdValid !== 1'b0 || MisalignErr !== 1'b0 || RdData !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid_outputs: busy=%b valid=%b mis=%b data=%h, want all 0",
                  Busy, RdValid, MisalignErr, RdData);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      do_load("lw_020_after_rst", F_W, 9'h020, 32'h55551234, 0);
   endtask

   task automatic test_misalign;
      logic [4:0] b, v, m;
      logic [31:0] d, dl;
      run_access(1'b1, 1'b0, F_W, 9'h013, 32'h0, 0, b, v, m, d, dl);
      checks++;
      if (v !== 5'b00100) begin
         errors++;
         $display("FAIL mis_lw_valid: got %b want 00100", v);
      end
`ifdef DMEM_MISALIGN_TRAP_EN
      checks++;
      if (m !== 5'b00100 || d !== 32'h0) begin
         errors++;
         $display("FAIL mis_lw_trap: mis=%b data=%h, want mis=00100 data=00000000", m, d);
      end
`else
      checks++;
      if (m !== 5'b00000 || d !== 32'h123480EF) begin
         errors++;
         $display("FAIL mis_lw_align: mis=%b data=%h, want mis=00000 data=123480ef", m, d);
      end
      do_load("lh_013_aligned", F_H, 9'h013, 32'h00001234, 0);
`endif
   endtask

   task automatic test_corner_cases;
      // Both strobes high behaves as a store.
      do_store("sw_both_030", F_W, 9'h030, 32'h0BADF00D, 1'b1);
      do_load("lw_030", F_W, 9'h030, 32'h0BADF00D, 0);
      do_load("lrsv_030", F_RSV, 9'h030, 32'h0BADF00D, 0);
      do_load("lhu_032", F_HU, 9'h032, 32'h00000BAD, 0);
      do_load("lh_030", F_H, 9'h030, 32'hFFFFF00D, 0);
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_held_request();
      test_reset_mid_access();
      test_misalign();
      test_corner_cases();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
